// File: rtl/ntt_mem_arbiter_if.sv
// Bus bundle between the NTT core array, the shared-memory arbiter and the coefficient memory.
// master = arbiter side, slave = core/memory side.
interface ntt_mem_arbiter_if #(
  parameter int unsigned N_CORES = 4,
  parameter int unsigned AW      = 64,
  parameter int unsigned DW      = 64
);
  logic [N_CORES-1:0]    core_req;
  logic [N_CORES-1:0]    core_we;
  logic [N_CORES*AW-1:0] core_addr;
  logic [N_CORES*DW-1:0] core_wdata;
  logic [N_CORES-1:0]    core_gnt;
  logic [N_CORES-1:0]    core_valid;
  logic [DW-1:0]         core_rdata;
  logic                  mem_req;
  logic                  mem_we;
  logic [AW-1:0]         mem_addr;
  logic [DW-1:0]         mem_wdata;
  logic                  mem_gnt;
  logic                  mem_valid;
  logic [DW-1:0]         mem_rdata;
  logic                  busy;
  logic [32*N_CORES-1:0] perf_grants;

  modport master (
    input  core_req, core_we, core_addr, core_wdata, mem_gnt, mem_valid, mem_rdata,
    output core_gnt, core_valid, core_rdata, mem_req, mem_we, mem_addr, mem_wdata,
           busy, perf_grants
  );

  modport slave (
    output core_req, core_we, core_addr, core_wdata, mem_gnt, mem_valid, mem_rdata,
    input  core_gnt, core_valid, core_rdata, mem_req, mem_we, mem_addr, mem_wdata,
           busy, perf_grants
  );
endinterface

// File: rtl/ntt_mem_arbiter.sv
// Round-robin arbiter merging single-outstanding NTT core memory ports onto one memory port.
// Optional per-core completion counters are built when NTT_ARB_PERF_EN is defined.
module ntt_mem_arbiter #(
  parameter int unsigned N_CORES = 4,
  parameter int unsigned AW      = 64,
  parameter int unsigned DW      = 64
) (
  input logic               clk,
  input logic               rst,
  ntt_mem_arbiter_if.master bus
);
  localparam int unsigned SELW = $clog2(N_CORES);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_RD, COMPLETE} state_t;

  state_t             state_q, state_d;
  logic [SELW-1:0]    rr_ptr_q, rr_ptr_d;
  logic [SELW-1:0]    sel_q, sel_d;
  logic               we_q, we_d;
  logic [AW-1:0]      addr_q, addr_d;
  logic [DW-1:0]      wdata_q, wdata_d;
  logic [DW-1:0]      rdata_q, rdata_d;
  logic [N_CORES-1:0] cool_q, cool_d;

  logic [N_CORES-1:0] masked;
  logic [N_CORES-1:0] sel_onehot;
  int unsigned        pick_idx;
  int unsigned        best_rank;
  int unsigned        rank;
  logic               found;
  logic               pick_we;
  logic [AW-1:0]      pick_addr;
  logic [DW-1:0]      pick_wdata;

  assign masked = bus.core_req & ~cool_q;

  // Lowest rank = closest set bit at or above rr_ptr, wrapping modulo N_CORES.
  always_comb begin
    best_rank = N_CORES;
    pick_idx  = 0;
    rank      = 0;
    for (int unsigned i = 0; i < N_CORES; i++) begin
      if (masked[i]) begin
        rank = (i + N_CORES - 32'(rr_ptr_q)) % N_CORES;
        if (rank < best_rank) begin
          best_rank = rank;
          pick_idx  = i;
        end
      end
    end
    found = (best_rank < N_CORES);
  end

  always_comb begin
    pick_we    = 1'b0;
    pick_addr  = '0;
    pick_wdata = '0;
    for (int unsigned i = 0; i < N_CORES; i++) begin
      if (i == pick_idx) begin
        pick_we    = bus.core_we[i];
        pick_addr  = bus.core_addr[i*AW +: AW];
        pick_wdata = bus.core_wdata[i*DW +: DW];
      end
    end
  end

  always_comb begin
    sel_onehot = '0;
    for (int unsigned i = 0; i < N_CORES; i++) begin
      sel_onehot[i] = (32'(sel_q) == i);
    end
  end

  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    sel_d    = sel_q;
    we_d     = we_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    rdata_d  = rdata_q;
    cool_d   = '0;
    unique case (state_q)
      IDLE: begin
        if (found) begin
          sel_d   = SELW'(pick_idx);
          we_d    = pick_we;
          addr_d  = pick_addr;
          wdata_d = pick_wdata;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        if (bus.mem_gnt) state_d = we_q ? COMPLETE : WAIT_RD;
      end
      WAIT_RD: begin
        if (bus.mem_valid) begin
          rdata_d = bus.mem_rdata;
          state_d = COMPLETE;
        end
      end
      COMPLETE: begin
        rr_ptr_d = SELW'((32'(sel_q) + 32'd1) % N_CORES);
        cool_d   = sel_onehot;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      rr_ptr_q <= '0;
      sel_q    <= '0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
      cool_q   <= '0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      sel_q    <= sel_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      rdata_q  <= rdata_d;
      cool_q   <= cool_d;
    end
  end

  assign bus.mem_req    = (state_q == ISSUE);
  assign bus.mem_we     = we_q;
  assign bus.mem_addr   = addr_q;
  assign bus.mem_wdata  = wdata_q;
  assign bus.core_gnt   = (state_q == COMPLETE) ? sel_onehot : '0;
  assign bus.core_valid = (state_q == COMPLETE && !we_q) ? sel_onehot : '0;
  assign bus.core_rdata = rdata_q;
  assign bus.busy       = (state_q != IDLE);

`ifdef NTT_ARB_PERF_EN
  logic [31:0] perf_q [N_CORES];

  always_ff @(posedge clk) begin
    for (int unsigned i = 0; i < N_CORES; i++) begin
      if (rst) begin
        perf_q[i] <= '0;
      end else if (state_q == COMPLETE && sel_onehot[i]) begin
        perf_q[i] <= perf_q[i] + 32'd1;
      end
    end
  end

  for (genvar g = 0; g < N_CORES; g++) begin : g_perf
    assign bus.perf_grants[g*32 +: 32] = perf_q[g];
  end
`else
  assign bus.perf_grants = '0;
`endif
endmodule

// File: tb/tb_ntt_mem_arbiter.sv
// Directed-vector bench for ntt_mem_arbiter; expected values are hand-derived cycle by cycle.
module tb_ntt_mem_arbiter;
  localparam int unsigned N  = 4;
  localparam int unsigned AW = 64;
  localparam int unsigned DW = 64;

  logic clk = 1'b0;
  logic rst;
  int   vectors = 0;
  int   miscompares = 0;
  logic [N-1:0] drop1, drop2;

  always #5 clk = ~clk;

  ntt_mem_arbiter_if #(.N_CORES(N), .AW(AW), .DW(DW)) bus ();

  ntt_mem_arbiter #(.N_CORES(N), .AW(AW), .DW(DW)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
  );

  // Advance one cycle; a core drops its req on the edge after it samples gnt.
  task automatic tick();
    @(posedge clk);
    #1;
    bus.core_req = bus.core_req & ~drop2;
    drop2 = drop1;
    drop1 = bus.core_gnt;
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    bus.core_req = '0;
    bus.core_we = '0;
    bus.core_addr = '0;
    bus.core_wdata = '0;
    bus.mem_gnt = 1'b0;
    bus.mem_valid = 1'b0;
    bus.mem_rdata = '0;
    drop1 = '0;
    drop2 = '0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  // Single write transaction for core c with an always-ready memory.
  task automatic run_txn(input int unsigned c, output bit ok);
    ok = 1'b0;
    bus.core_we[c] = 1'b1;
    bus.core_req[c] = 1'b1;
    bus.mem_gnt = 1'b1;
    for (int unsigned t = 0; t < 20; t++) begin
      tick();
      if (bus.core_gnt[c]) begin
        ok = 1'b1;
        break;
      end
    end
    bus.mem_gnt = 1'b0;
    tick();
    tick();
    tick();
  endtask

  task automatic test_reset();
    apply_reset();
    vectors++; if (bus.mem_req !== 1'b0) begin miscompares++; $display("FAIL rst_mem_req: got %0h want 0", bus.mem_req); end
    vectors++; if (bus.mem_we !== 1'b0) begin miscompares++; $display("FAIL rst_mem_we: got %0h want 0", bus.mem_we); end
    vectors++; if (bus.mem_addr !== '0) begin miscompares++; $display("FAIL rst_mem_addr: got %0h want 0", bus.mem_addr); end
    vectors++; if (bus.core_gnt !== '0) begin miscompares++; $display("FAIL rst_core_gnt: got %0h want 0", bus.core_gnt); end
    vectors++; if (bus.core_valid !== '0) begin miscompares++; $display("FAIL rst_core_valid: got %0h want 0", bus.core_valid); end
    vectors++; if (bus.busy !== 1'b0) begin miscompares++; $display("FAIL rst_busy: got %0h want 0", bus.busy); end
  endtask

  task automatic test_write();
    apply_reset();
    bus.core_addr[0 +: AW] = 64'h8;
    bus.core_wdata[0 +: DW] = 64'hDEADBEEF;
    bus.core_we = 4'b0001;
    bus.core_req = 4'b0001;
    tick();
    vectors++; if (bus.mem_req !== 1'b1) begin miscompares++; $display("FAIL wr_mem_req: got %0h want 1", bus.mem_req); end
    vectors++; if (bus.mem_we !== 1'b1) begin miscompares++; $display("FAIL wr_mem_we: got %0h want 1", bus.mem_we); end
    vectors++; if (bus.mem_addr !== 64'h8) begin miscompares++; $display("FAIL wr_mem_addr: got %0h want 8", bus.mem_addr); end
    vectors++; if (bus.mem_wdata !== 64'hDEADBEEF) begin miscompares++; $display("FAIL wr_mem_wdata: got %0h want deadbeef", bus.mem_wdata); end
    vectors++; if (bus.busy !== 1'b1) begin miscompares++; $display("FAIL wr_busy: got %0h want 1", bus.busy); end
    tick();
    vectors++; if (bus.mem_req !== 1'b1) begin miscompares++; $display("FAIL wr_mem_req_hold: got %0h want 1", bus.mem_req); end
    vectors++; if (bus.core_gnt !== 4'b0000) begin miscompares++; $display("FAIL wr_gnt_early: got %0h want 0", bus.core_gnt); end
    bus.mem_gnt = 1'b1;
    tick();
    bus.mem_gnt = 1'b0;
    vectors++; if (bus.core_gnt !== 4'b0001) begin miscompares++; $display("FAIL wr_core_gnt: got %0h want 1", bus.core_gnt); end
    vectors++; if (bus.core_valid !== 4'b0000) begin miscompares++; $display("FAIL wr_core_valid: got %0h want 0", bus.core_valid); end
    vectors++; if (bus.mem_req !== 1'b0) begin miscompares++; $display("FAIL wr_mem_req_drop: got %0h want 0", bus.mem_req); end
    tick();
    vectors++; if (bus.core_gnt !== 4'b0000) begin miscompares++; $display("FAIL wr_gnt_once: got %0h want 0", bus.core_gnt); end
    tick();
    vectors++; if (bus.busy !== 1'b0) begin miscompares++; $display("FAIL wr_cooldown_busy: got %0h want 0", bus.busy); end
    tick();
    vectors++; if (bus.busy !== 1'b0) begin miscompares++; $display("FAIL wr_idle_busy: got %0h want 0", bus.busy); end
  endtask

  task automatic test_read();
    apply_reset();
    bus.core_addr[2*AW +: AW] = 64'd200;
    bus.core_we = 4'b0000;
    bus.core_req = 4'b0100;
    tick();
    vectors++; if (bus.mem_req !== 1'b1) begin miscompares++; $display("FAIL rd_mem_req: got %0h want 1", bus.mem_req); end
    vectors++; if (bus.mem_addr !== 64'd200) begin miscompares++; $display("FAIL rd_mem_addr: got %0d want 200", bus.mem_addr); end
    vectors++; if (bus.mem_we !== 1'b0) begin miscompares++; $display("FAIL rd_mem_we: got %0h want 0", bus.mem_we); end
    bus.mem_gnt = 1'b1;
    tick();
    bus.mem_gnt = 1'b0;
    vectors++; if (bus.mem_req !== 1'b0) begin miscompares++; $display("FAIL rd_mem_req_drop: got %0h want 0", bus.mem_req); end
    vectors++; if (bus.busy !== 1'b1) begin miscompares++; $display("FAIL rd_busy_wait: got %0h want 1", bus.busy); end
    tick();
    vectors++; if (bus.core_gnt !== 4'b0000) begin miscompares++; $display("FAIL rd_gnt_early1: got %0h want 0", bus.core_gnt); end
    tick();
    vectors++; if (bus.core_gnt !== 4'b0000) begin miscompares++; $display("FAIL rd_gnt_early2: got %0h want 0", bus.core_gnt); end
    bus.mem_valid = 1'b1;
    bus.mem_rdata = 64'h1234;
    tick();
    bus.mem_valid = 1'b0;
    bus.mem_rdata = 64'hFFFF;
    vectors++; if (bus.core_gnt !== 4'b0100) begin miscompares++; $display("FAIL rd_core_gnt: got %0h want 4", bus.core_gnt); end
    vectors++; if (bus.core_valid !== 4'b0100) begin miscompares++; $display("FAIL rd_core_valid: got %0h want 4", bus.core_valid); end
    vectors++; if (bus.core_rdata !== 64'h1234) begin miscompares++; $display("FAIL rd_core_rdata: got %0h want 1234", bus.core_rdata); end
    tick();
    tick();
    tick();
    bus.mem_valid = 1'b1;
    bus.mem_rdata = 64'h5555;
    tick();
    bus.mem_valid = 1'b0;
    tick();
    vectors++; if (bus.busy !== 1'b0) begin miscompares++; $display("FAIL rd_stray_busy: got %0h want 0", bus.busy); end
    vectors++; if (bus.core_rdata !== 64'h1234) begin miscompares++; $display("FAIL rd_stray_rdata: got %0h want 1234", bus.core_rdata); end
  endtask

  task automatic test_all_cores();
    int unsigned order [4];
    int unsigned cnt [4];
    int unsigned n;
    apply_reset();
    n = 0;
    for (int unsigned i = 0; i < N; i++) begin
      order[i] = 99;
      cnt[i] = 0;
      bus.core_addr[i*AW +: AW] = 64'(16 * i);
    end
    bus.core_we = 4'b1111;
    bus.core_req = 4'b1111;
    bus.mem_gnt = 1'b1;
    for (int unsigned t = 0; t < 40; t++) begin
      tick();
      for (int unsigned i = 0; i < N; i++) begin
        if (bus.core_gnt[i]) begin
          cnt[i]++;
          if (n < 4) order[n] = i;
          n++;
        end
      end
    end
    bus.mem_gnt = 1'b0;
    vectors++; if (n != 4) begin miscompares++; $display("FAIL all_total_grants: got %0d want 4", n); end
    for (int unsigned k = 0; k < N; k++) begin
      vectors++; if (order[k] != k) begin miscompares++; $display("FAIL all_order[%0d]: got %0d want %0d", k, order[k], k); end
      vectors++; if (cnt[k] != 1) begin miscompares++; $display("FAIL all_count[%0d]: got %0d want 1", k, cnt[k]); end
    end
  endtask

  task automatic test_rr_ptr();
    int unsigned order [2];
    int unsigned n;
    bit ok;
    apply_reset();
    run_txn(1, ok);
    vectors++; if (!ok) begin miscompares++; $display("FAIL rr_setup_gnt: got none want core1 gnt within 20 cycles"); end
    n = 0;
    order[0] = 99;
    order[1] = 99;
    bus.core_we = 4'b1001;
    bus.core_req = 4'b1001;
    bus.mem_gnt = 1'b1;
    for (int unsigned t = 0; t < 20; t++) begin
      tick();
      for (int unsigned i = 0; i < N; i++) begin
        if (bus.core_gnt[i]) begin
          if (n < 2) order[n] = i;
          n++;
        end
      end
    end
    bus.mem_gnt = 1'b0;
    vectors++; if (n != 2) begin miscompares++; $display("FAIL rr_total_grants: got %0d want 2", n); end
    vectors++; if (order[0] != 3) begin miscompares++; $display("FAIL rr_first: got %0d want 3", order[0]); end
    vectors++; if (order[1] != 0) begin miscompares++; $display("FAIL rr_second: got %0d want 0", order[1]); end
  endtask

  task automatic test_reset_mid();
    apply_reset();
    bus.core_we = 4'b0000;
    bus.core_req = 4'b0010;
    bus.core_addr[1*AW +: AW] = 64'h40;
    tick();
    bus.mem_gnt = 1'b1;
    tick();
    bus.mem_gnt = 1'b0;
    vectors++; if (bus.busy !== 1'b1) begin miscompares++; $display("FAIL mid_pre_busy: got %0h want 1", bus.busy); end
    rst = 1'b1;
    bus.core_req = '0;
    drop1 = '0;
    drop2 = '0;
    tick();
    rst = 1'b0;
    bus.mem_valid = 1'b1;
    bus.mem_rdata = 64'hABCD;
    tick();
    bus.mem_valid = 1'b0;
    for (int unsigned t = 0; t < 3; t++) begin
      tick();
      vectors++; if (bus.core_gnt !== '0 || bus.core_valid !== '0) begin miscompares++; $display("FAIL mid_no_gnt: got gnt=%0h valid=%0h want 0/0", bus.core_gnt, bus.core_valid); end
    end
    vectors++; if (bus.busy !== 1'b0) begin miscompares++; $display("FAIL mid_busy: got %0h want 0", bus.busy); end
    vectors++; if (bus.mem_req !== 1'b0) begin miscompares++; $display("FAIL mid_mem_req: got %0h want 0", bus.mem_req); end
    vectors++; if (bus.mem_addr !== '0) begin miscompares++; $display("FAIL mid_mem_addr: got %0h want 0", bus.mem_addr); end
    vectors++; if (bus.core_rdata !== '0) begin miscompares++; $display("FAIL mid_core_rdata: got %0h want 0", bus.core_rdata); end
    vectors++; if (bus.perf_grants !== '0) begin miscompares++; $display("FAIL mid_perf: got %0h want 0", bus.perf_grants); end
  endtask

  task automatic test_perf();
    logic [32*N-1:0] exp_perf;
    bit ok;
    bit all_ok;
    apply_reset();
    all_ok = 1'b1;
    exp_perf = '0;
`ifdef NTT_ARB_PERF_EN
    exp_perf[1*32 +: 32] = 32'd5;
    exp_perf[3*32 +: 32] = 32'd2;
`endif
    for (int unsigned k = 0; k < 5; k++) begin
      run_txn(1, ok);
      all_ok = all_ok & ok;
    end
    for (int unsigned k = 0; k < 2; k++) begin
      run_txn(3, ok);
      all_ok = all_ok & ok;
    end
    vectors++; if (!all_ok) begin miscompares++; $display("FAIL perf_txn_gnt: got missing gnt want all 7 granted"); end
    for (int unsigned i = 0; i < N; i++) begin
      vectors++; if (bus.perf_grants[i*32 +: 32] !== exp_perf[i*32 +: 32]) begin miscompares++; $display("FAIL perf_slice[%0d]: got %0d want %0d", i, bus.perf_grants[i*32 +: 32], exp_perf[i*32 +: 32]); end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_write();
    test_read();
    test_all_cores();
    test_rr_ptr();
    test_reset_mid();
    test_perf();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/ntt_mem_arbiter.md
Name: ntt_mem_arbiter

Overview:
- Downstream of the NTT cores. Merges the single-outstanding memory ports of N_CORES cores onto one shared memory port, using round-robin arbitration.
- Each core holds its request high until it sees a one-cycle grant pulse. The arbiter issues that grant only after the memory transaction completes: write accepted, or read data returned.
- Sits between the core array and the coefficient memory/controller.

Parameters:
- N_CORES, 4, number of requesting cores (2..8).
- AW, 64, address width.
- DW, 64, data width.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- core_req  in  N_CORES  per-core request, held until granted.
- core_we  in  N_CORES  per-core write enable (1=write, 0=read).
- core_addr  in  N_CORES*AW  packed addresses, core i at [i*AW +: AW].
- core_wdata  in  N_CORES*DW  packed write data, same packing.
- core_gnt  out  N_CORES  one-hot, one-cycle completion pulse.
- core_valid  out  N_CORES  one-hot read-data-valid, asserted with core_gnt on reads only.
- core_rdata  out  DW  read data, broadcast, meaningful only with core_valid.
- mem_req  out  1  shared memory request.
- mem_we  out  1  shared write enable.
- mem_addr  out  AW  shared address.
- mem_wdata  out  DW  shared write data.
- mem_gnt  in  1  memory accepts the request this cycle.
- mem_valid  in  1  read data valid (arrives 1+ cycles after accept).
- mem_rdata  in  DW  read data.
- busy  out  1  high whenever the arbiter is not in IDLE.
- perf_grants  out  32*N_CORES  per-core completed-transaction counters (see Optional Feature).

Behaviour:
- Reset values: all outputs 0; rr_ptr = 0; state = IDLE. Reset mid-transaction abandons it: no gnt is issued, and a late mem_valid after reset is ignored.
- IDLE:
  - Masked requests = core_req & ~cooldown_mask.
  - If any are set, pick the first set bit scanning from rr_ptr upward, wrapping modulo N_CORES.
  - Latch sel, we, addr and wdata from that core into registers.
  - Next cycle: mem_req=1 and registered fields driven; state → ISSUE.
- ISSUE:
  - Hold mem_req and all fields stable until mem_gnt=1.
  - On mem_gnt: mem_req←0. Write → COMPLETE. Read → WAIT_RD.
- WAIT_RD:
  - mem_req=0. On mem_valid, latch mem_rdata into core_rdata → COMPLETE.
  - mem_valid in any other state is ignored.
- COMPLETE:
  - core_gnt[sel]=1 for exactly this cycle; for reads, core_valid[sel]=1 in the same cycle.
  - rr_ptr ← (sel+1) mod N_CORES.
  - cooldown_mask ← one-hot(sel) → IDLE.
- Cooldown:
  - The core drops core_req on the edge after it samples gnt, so its req is still visible in the first IDLE cycle.
  - cooldown_mask suppresses that core for exactly one IDLE cycle, then clears.
  - Other cores may win arbitration in that cycle.
- Latency, no contention:
  - Write: req seen → mem_req 1 cycle later → gnt 1 cycle after mem_gnt.
  - Read: gnt 1 cycle after mem_valid.
- Requests that drop before being selected are simply not served; there are no side effects.
- core_req for a core index ≥ N_CORES does not exist. All vectors are sized exactly.
- At most one transaction is outstanding at any time.
- No timeout: a hung memory leaves the arbiter in ISSUE/WAIT_RD with busy=1 until rst.

Optional Feature:
- NTT_ARB_PERF_EN defined:
  - perf_grants holds a 32-bit counter per core, incremented in the COMPLETE cycle for sel.
  - Counters wrap at 2^32 and reset to 0 on rst.
- NTT_ARB_PERF_EN undefined:
  - perf_grants is tied to 0 and no counter registers are generated.
  - All other behaviour is identical.

Test Plan:
- Single core 0, write, addr 0x8, wdata 0xDEADBEEF, mem_gnt 1 cycle after mem_req → mem_addr=0x8, mem_wdata=0xDEADBEEF, mem_we=1; core_gnt=0001 one cycle after mem_gnt; core_valid stays 0.
- Core 2 read, addr 200, mem_valid 3 cycles after accept with rdata 0x1234 → core_gnt=0100 and core_valid=0100 in the same cycle, core_rdata=0x1234.
- All 4 cores request simultaneously, holding until granted, writes only → grant order 0,1,2,3; each core granted exactly once; no second grant to any core while its req is still high in the cooldown cycle.
- rr_ptr=2 after serving core 1; cores 0 and 3 request → core 3 served before core 0.
- rst asserted while in WAIT_RD, then mem_valid pulses → no core_gnt/core_valid; all outputs 0; busy=0.
- With NTT_ARB_PERF_EN, 5 transactions for core 1 and 2 for core 3 → perf_grants slice 1 = 5, slice 3 = 2, others 0. Without the macro → perf_grants = 0.
